// File: rtl/scaler_v_if.sv
// Pixel stream bundle between the horizontal scaler, the vertical scaler and its consumer.
// Latency: none (wires only).
// Backpressure: none; the stream is push-only and qualified by de.
//
// master: drives the input stream (di_i/de_i/hs_i/vs_i) and observes the scaled output.
// slave : consumes the input stream and drives the scaled output (do_o/de_o/hs_o/vs_o).
interface scaler_v_if #(
    parameter int PIXEL_WIDTH = 12
);
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (
        output di_i, de_i, hs_i, vs_i,
        input  do_o, de_o, hs_o, vs_o
    );

    modport slave (
        input  di_i, de_i, hs_i, vs_i,
        output do_o, de_o, hs_o, vs_o
    );
endinterface

// File: rtl/scaler_v.sv
// Vertical linear downscaler: blends each emitted line with the stored previous line.
// Latency: fixed 4 clk from de_i to de_o/do_o (RAM read, multiply, sum, output register).
// Backpressure: none; output mirrors the de_i pattern of emitted lines.
//
// Ports: clk, rst_n (async active-low), scale_step (vertical step, PIXEL_STEP = 1.0),
//        vid (slave): di_i/de_i/hs_i/vs_i in, do_o/de_o/hs_o/vs_o out.
module scaler_v #(
    parameter VENDOR_RAM_STYLE = "MLAB",
    parameter int PIXEL_STEP     = 4096,
    parameter int PIXEL_WIDTH    = 12,
    parameter int COE_WIDTH      = 10,
    parameter int MAX_LINE_WIDTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] scale_step,
    scaler_v_if.slave   vid
);
    localparam int LW    = 24;
    localparam int AW    = $clog2(MAX_LINE_WIDTH);
    localparam int XW    = AW + 1;
    localparam int SH    = $clog2(PIXEL_STEP) - (COE_WIDTH - 1);
    localparam int MW    = PIXEL_WIDTH + COE_WIDTH;
    localparam int SW    = PIXEL_WIDTH + COE_WIDTH + 1;
    localparam int UNITY = 1 << (COE_WIDTH - 1);
    localparam int ROUND = 1 << (COE_WIDTH - 2);

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    state_t                 state;
    logic [15:0]            step;
    logic [LW-1:0]          lk;
    logic [LW-1:0]          p;
    logic                   emit_line;
    logic [COE_WIDTH-1:0]   wp_line;
    logic [XW-1:0]          x;

    // Stage 1: RAM read + latched current pixel and weight
    logic                   s1_vld, s1_hs, s1_vs;
    logic [PIXEL_WIDTH-1:0] s1_di;
    logic [COE_WIDTH-1:0]   s1_wp;
    logic [PIXEL_WIDTH-1:0] rd_q;
    // Stage 2: products
    logic                   s2_vld, s2_hs, s2_vs;
    logic [MW-1:0]          m_cur, m_prev;
    // Stage 3: rounded sum
    logic                   s3_vld, s3_hs, s3_vs;
    logic [SW-1:0]          sum;

    (* ramstyle = VENDOR_RAM_STYLE *) logic [PIXEL_WIDTH-1:0] mem [MAX_LINE_WIDTH];

    // Per-pixel view of the line counters, including this pixel's own hs/vs effect.
    logic                 is_fs, is_ls, take, hit_now, emit_px, in_buf;
    logic [15:0]          step_clamp;
    logic [LW-1:0]        lk_now, p_now, f_now;
    logic [COE_WIDTH-1:0] wp_calc, wp_px, s1_wc;
    logic [XW-1:0]        x_now;
    logic [SW-1:0]        shifted;
    logic [PIXEL_WIDTH-1:0] do_sat;

    always_comb begin
        is_fs      = vid.de_i & vid.hs_i & vid.vs_i;
        is_ls      = vid.de_i & vid.hs_i & ~vid.vs_i;
        take       = vid.de_i & ((state == ACTIVE) | is_fs);
        step_clamp = (scale_step < 16'(PIXEL_STEP)) ? 16'(PIXEL_STEP) : scale_step;
        lk_now     = is_fs ? '0 : (is_ls ? lk + LW'(PIXEL_STEP) : lk);
        p_now      = is_fs ? '0 : p;
        hit_now    = (p_now <= lk_now);
        f_now      = lk_now - p_now;
        wp_calc    = COE_WIDTH'(f_now >> SH);
        x_now      = vid.hs_i ? '0 : x;
        in_buf     = (x_now < XW'(MAX_LINE_WIDTH));
        emit_px    = vid.hs_i ? hit_now : emit_line;
        // Beyond the buffer there is no valid previous pixel, so use the current line only.
        wp_px      = in_buf ? (vid.hs_i ? wp_calc : wp_line) : '0;
        s1_wc      = COE_WIDTH'(UNITY) - s1_wp;
        shifted    = sum >> (COE_WIDTH - 1);
        do_sat     = (|shifted[SW-1:PIXEL_WIDTH]) ? {PIXEL_WIDTH{1'b1}} : shifted[PIXEL_WIDTH-1:0];
    end

    // Line buffer: registered read returns the old word when the same address is written.
    always_ff @(posedge clk) begin
        if (take) begin
            rd_q <= mem[x_now[AW-1:0]];
            if (in_buf)
                mem[x_now[AW-1:0]] <= vid.di_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_FRAME;
            step      <= '0;
            lk        <= '0;
            p         <= '0;
            emit_line <= 1'b0;
            wp_line   <= '0;
            x         <= '0;
            s1_vld    <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_di     <= '0;
            s1_wp     <= '0;
            s2_vld    <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            m_cur     <= '0;
            m_prev    <= '0;
            s3_vld    <= 1'b0;
            s3_hs     <= 1'b0;
            s3_vs     <= 1'b0;
            sum       <= '0;
            vid.do_o  <= '0;
            vid.de_o  <= 1'b0;
            vid.hs_o  <= 1'b0;
            vid.vs_o  <= 1'b0;
        end else begin
            if (is_fs) begin
                state <= ACTIVE;
                step  <= step_clamp;
            end

            if (take) begin
                x <= in_buf ? x_now + 1'b1 : x_now;
                if (vid.hs_i) begin
                    lk        <= lk_now;
                    emit_line <= hit_now;
                    if (hit_now) begin
                        p       <= p_now + LW'(is_fs ? step_clamp : step);
                        wp_line <= wp_calc;
                    end else begin
                        p       <= p_now;
                    end
                end
                s1_di <= vid.di_i;
                s1_wp <= wp_px;
            end
            s1_vld <= take & emit_px;
            s1_hs  <= take & vid.hs_i & hit_now;
            s1_vs  <= take & is_fs;

            s2_vld <= s1_vld;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            m_cur  <= MW'(s1_di) * MW'(s1_wc);
            m_prev <= MW'(rd_q) * MW'(s1_wp);

            s3_vld <= s2_vld;
            s3_hs  <= s2_hs;
            s3_vs  <= s2_vs;
            sum    <= SW'(m_cur) + SW'(m_prev) + SW'(ROUND);

            vid.de_o <= s3_vld;
            vid.hs_o <= s3_hs;
            vid.vs_o <= s3_vs;
            if (s3_vld)
                vid.do_o <= do_sat;
        end
    end
endmodule

// File: tb/tb_scaler_v.sv
// Directed bench for scaler_v: ratios 1:1, 2:1, 1.5:1, saturation, rounding, clamp,
// pre-frame drop and mid-line reset, with hand-computed expected output lines.
// Output stream is captured on the falling edge and compared pixel by pixel.
module tb_scaler_v;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] scale_step;

    always #5 clk = ~clk;

    scaler_v_if #(.PIXEL_WIDTH(12)) vid ();

    scaler_v dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scale_step (scale_step),
        .vid        (vid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int q_val[$];
    int q_hs[$];
    int q_vs[$];
    int in_cyc  = -1;
    int out_cyc = -1;

    always @(negedge clk) begin
        if (vid.de_o === 1'b1) begin
            q_val.push_back(int'(vid.do_o));
            q_hs.push_back(int'(vid.hs_o));
            q_vs.push_back(int'(vid.vs_o));
            if (out_cyc < 0) out_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vid.de_i = 1'b0;
            vid.hs_i = 1'b0;
            vid.vs_i = 1'b0;
        end
    endtask

    task automatic drive_px(input int v, input bit hs, input bit vs);
        @(posedge clk); #1;
        vid.di_i = 12'(v);
        vid.de_i = 1'b1;
        vid.hs_i = hs;
        vid.vs_i = vs;
        if (in_cyc < 0) in_cyc = cyc;
    endtask

    // 8-pixel line; gap_at >= 0 inserts a 2-cycle de_i hole before that pixel.
    task automatic send_line(input int v, input bit vs, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) idle(2);
            drive_px(v, i == 0, vs && (i == 0));
        end
        idle(3);
    endtask

    task automatic send_frame(input int v[4], input bit with_vs, input int gap_at);
        for (int l = 0; l < 4; l++)
            send_line(v[l], with_vs && (l == 0), gap_at);
        idle(8);
    endtask

    task automatic clear_mon();
        q_val.delete();
        q_hs.delete();
        q_vs.delete();
        in_cyc  = -1;
        out_cyc = -1;
    endtask

    task automatic check_out(input string tag, input int n_lines, input int e[4]);
        int n;
        check($sformatf("%s.npx", tag), q_val.size(), n_lines * 8);
        n = (q_val.size() < n_lines * 8) ? q_val.size() : n_lines * 8;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.do[%0d]", tag, i), q_val[i], e[i/8]);
            check($sformatf("%s.hs[%0d]", tag, i), q_hs[i], (i % 8 == 0) ? 1 : 0);
            check($sformatf("%s.vs[%0d]", tag, i), q_vs[i], (i == 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        scale_step = 16'd4096;
        vid.di_i   = '0;
        vid.de_i   = 1'b0;
        vid.hs_i   = 1'b0;
        vid.vs_i   = 1'b0;
        #2;
        check("rst.de_o", vid.de_o, 0);
        check("rst.hs_o", vid.hs_o, 0);
        check("rst.vs_o", vid.vs_o, 0);
        check("rst.do_o", vid.do_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Lines without a frame start are dropped
        scale_step = 16'd2000;
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b0, -1);
        check("drop.npx", q_val.size(), 0);

        // 1:1 with de_i gaps, latency check
        scale_step = 16'd4096;
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b1, 4);
        check("r11.latency", out_cyc - in_cyc, 4);
        check_out("r11", 4, '{100, 200, 300, 400});

        // 2:1
        scale_step = 16'd8192;
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b1, -1);
        check_out("r21", 2, '{100, 300, 0, 0});

        // 1.5:1
        scale_step = 16'd6144;
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b1, -1);
        check_out("r15", 3, '{100, 250, 400, 0});

        // Full-scale input stays at full scale
        clear_mon();
        send_frame('{4095, 4095, 4095, 4095}, 1'b1, -1);
        check_out("sat", 3, '{4095, 4095, 4095, 0});

        // Half weight on 1 and 0 rounds up to 1
        clear_mon();
        send_frame('{0, 1, 0, 1}, 1'b1, -1);
        check_out("rnd", 3, '{0, 1, 1, 0});

        // Steps below 1.0 clamp to 1:1
        scale_step = 16'd2000;
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b1, -1);
        check_out("clamp", 4, '{100, 200, 300, 400});

        // Reset in the middle of line 1
        scale_step = 16'd4096;
        clear_mon();
        send_line(100, 1'b1, -1);
        for (int i = 0; i < 4; i++) drive_px(200, i == 0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mrst.de_o", vid.de_o, 0);
        check("mrst.do_o", vid.do_o, 0);
        check("mrst.hs_o", vid.hs_o, 0);
        idle(3);
        rst_n = 1'b1;
        clear_mon();
        for (int i = 4; i < 8; i++) drive_px(200, 1'b0, 1'b0);
        idle(3);
        send_line(300, 1'b0, -1);
        send_line(400, 1'b0, -1);
        idle(8);
        check("mrst.npx", q_val.size(), 0);
        clear_mon();
        send_frame('{100, 200, 300, 400}, 1'b1, -1);
        check_out("mrst.r11", 4, '{100, 200, 300, 400});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
